// File: rtl/img_lut_pkg.sv
// Shared types for the image LUT datapath and its bank controller.
package img_lut_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDrain,
      StWaitSof
   } lut_ctrl_state_e;

endpackage

// File: rtl/img_lut_bank_ctrl.sv
// Double-buffered LUT bank controller: streams a coefficient table into the shadow
// bank, then swaps the active bank at the next start of frame.
module img_lut_bank_ctrl
   import img_lut_pkg::*;
#(
   parameter int unsigned PX_WIDTH = 10
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                load_start_i,
   input  logic [PX_WIDTH-1:0] coef_tdata_i,
   input  logic                coef_tvalid_i,
   input  logic                coef_tlast_i,
   output logic                coef_tready_o,
   input  logic                sof_i,
   output logic                lut_wr_en_o,
   output logic                lut_wr_bank_o,
   output logic [PX_WIDTH-1:0] lut_wr_addr_o,
   output logic [PX_WIDTH-1:0] lut_wr_data_o,
   output logic                active_bank_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned LUT_DEPTH = 2 ** PX_WIDTH;
   localparam logic [PX_WIDTH-1:0] LastAddr = PX_WIDTH'(LUT_DEPTH - 1);

   lut_ctrl_state_e state_q, state_d;
   logic [PX_WIDTH-1:0] cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d;
   logic                wr_bank_q, wr_bank_d;
   logic [PX_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [PX_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                active_q, active_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                beat_acc;
   logic                at_last;

   // Ready depends on the state register alone, never on input handshakes.
   assign coef_tready_o = (state_q == StLoad) || (state_q == StDrain);
   assign busy_o        = (state_q != StIdle);
   assign beat_acc      = coef_tvalid_i & coef_tready_o;
   assign at_last       = (cnt_q == LastAddr);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_bank_d = wr_bank_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      active_d  = active_q;
      done_d    = 1'b0;
      err_d     = err_q;

      unique case (state_q)
         StIdle: begin
            if (load_start_i) begin
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = StLoad;
            end
         end

         StLoad: begin
            if (beat_acc) begin
               wr_en_d   = 1'b1;
               wr_bank_d = ~active_q;
               wr_addr_d = cnt_q;
               wr_data_d = coef_tdata_i;
               if (coef_tlast_i) begin
                  if (at_last) begin
                     state_d = StWaitSof;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end
               end else if (at_last) begin
                  // Table too long: stop writing and swallow the rest of the packet.
                  err_d   = 1'b1;
                  state_d = StDrain;
               end
               if (!at_last) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         StDrain: begin
            if (beat_acc && coef_tlast_i) begin
               state_d = StIdle;
            end
         end

         StWaitSof: begin
            if (sof_i) begin
               active_d = ~active_q;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_bank_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_bank_q <= wr_bank_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         active_q  <= active_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign lut_wr_en_o   = wr_en_q;
   assign lut_wr_bank_o = wr_bank_q;
   assign lut_wr_addr_o = wr_addr_q;
   assign lut_wr_data_o = wr_data_q;
   assign active_bank_o = active_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_img_lut_bank_ctrl.sv
// Directed bench for img_lut_bank_ctrl at PX_WIDTH=4: loads, length errors, swap timing
// and mid-load reset.
module tb_img_lut_bank_ctrl;

   localparam int unsigned PxW = 4;

   logic           clk_i = 1'b0;
   logic           rst_n_i;
   logic           load_start_i;
   logic [PxW-1:0] coef_tdata_i;
   logic           coef_tvalid_i;
   logic           coef_tlast_i;
   logic           coef_tready_o;
   logic           sof_i;
   logic           lut_wr_en_o;
   logic           lut_wr_bank_o;
   logic [PxW-1:0] lut_wr_addr_o;
   logic [PxW-1:0] lut_wr_data_o;
   logic           active_bank_o;
   logic           busy_o;
   logic           done_o;
   logic           err_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned n_acc = 0;
   int unsigned n_done = 0;
   logic           log_bank[$];
   logic [PxW-1:0] log_addr[$];
   logic [PxW-1:0] log_data[$];

   img_lut_bank_ctrl #(.PX_WIDTH(PxW)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .load_start_i  (load_start_i),
      .coef_tdata_i  (coef_tdata_i),
      .coef_tvalid_i (coef_tvalid_i),
      .coef_tlast_i  (coef_tlast_i),
      .coef_tready_o (coef_tready_o),
      .sof_i         (sof_i),
      .lut_wr_en_o   (lut_wr_en_o),
      .lut_wr_bank_o (lut_wr_bank_o),
      .lut_wr_addr_o (lut_wr_addr_o),
      .lut_wr_data_o (lut_wr_data_o),
      .active_bank_o (active_bank_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Registered outputs are stable mid-cycle; record every write strobe and done pulse.
   always @(negedge clk_i) begin
      if (lut_wr_en_o) begin
         log_bank.push_back(lut_wr_bank_o);
         log_addr.push_back(lut_wr_addr_o);
         log_data.push_back(lut_wr_data_o);
      end
      if (done_o) n_done++;
   end

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      log_bank.delete();
      log_addr.delete();
      log_data.delete();
      n_done = 0;
      n_acc  = 0;
   endtask

   task automatic drive_beat(input logic [PxW-1:0] d, input logic last, input logic sof);
      @(negedge clk_i);
      coef_tvalid_i = 1'b1;
      coef_tdata_i  = d;
      coef_tlast_i  = last;
      sof_i         = sof;
      load_start_i  = 1'b0;
      #1;
      if (coef_tready_o) n_acc++;
   endtask

   task automatic idle_cycle(input logic ls);
      @(negedge clk_i);
      coef_tvalid_i = 1'b0;
      coef_tlast_i  = 1'b0;
      sof_i         = 1'b0;
      load_start_i  = ls;
      #1;
   endtask

   task automatic start_load();
      idle_cycle(1'b1);
      idle_cycle(1'b0);
   endtask

   // After the sof cycle the swap edge has passed: done_o must be high right now.
   task automatic pulse_sof(input string tag, input logic exp_swap);
      @(negedge clk_i);
      coef_tvalid_i = 1'b0;
      sof_i         = 1'b1;
      #1;
      idle_cycle(1'b0);
      check_eq({tag, "_done"}, int'(done_o), int'(exp_swap));
   endtask

   // Expected data for entry i is (base - i) mod 16.
   task automatic check_writes(input string tag, input int unsigned n, input logic bank,
                               input logic [PxW-1:0] base);
      logic [PxW-1:0] exp_d;
      int unsigned    bad;
      check_eq({tag, "_nwr"}, log_addr.size(), n);
      bad = 0;
      for (int i = 0; i < int'(n) && i < log_addr.size(); i++) begin
         exp_d = base - PxW'(i);
         if (log_bank[i] !== bank || log_addr[i] !== PxW'(i) || log_data[i] !== exp_d) bad++;
      end
      check_eq({tag, "_wr_entries_bad"}, bad, 0);
   endtask

   initial begin
      rst_n_i       = 1'b0;
      load_start_i  = 1'b0;
      coef_tdata_i  = '0;
      coef_tvalid_i = 1'b0;
      coef_tlast_i  = 1'b0;
      sof_i         = 1'b0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_ready", coef_tready_o, 0);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_active", active_bank_o, 0);
      check_eq("rst_wr_en", lut_wr_en_o, 0);
      check_eq("rst_err_done", {err_o, done_o}, 0);
      rst_n_i = 1'b1;
      idle_cycle(1'b0);

      // Full 16-entry load, swap five cycles after the last beat.
      clear_log();
      start_load();
      check_eq("s1_ready_in_load", coef_tready_o, 1);
      for (int i = 0; i < 16; i++) drive_beat(PxW'(15 - i), i == 15, 1'b0);
      idle_cycle(1'b0);
      check_eq("s1_busy_wait_sof", busy_o, 1);
      check_eq("s1_ready_wait_sof", coef_tready_o, 0);
      idle_cycle(1'b1);
      idle_cycle(1'b0);
      idle_cycle(1'b0);
      check_eq("s1_active_before_sof", active_bank_o, 0);
      pulse_sof("s1", 1'b1);
      check_eq("s1_active", active_bank_o, 1);
      check_writes("s1", 16, 1'b1, 4'd15);
      check_eq("s1_err", err_o, 0);
      idle_cycle(1'b0);
      check_eq("s1_done_once", n_done, 1);
      check_eq("s1_idle", busy_o, 0);

      // Short table: tlast on beat 9.
      clear_log();
      start_load();
      for (int i = 0; i < 10; i++) drive_beat(PxW'(7 - i), i == 9, 1'b0);
      idle_cycle(1'b0);
      check_writes("s2", 10, 1'b0, 4'd7);
      check_eq("s2_err", err_o, 1);
      check_eq("s2_idle", busy_o, 0);
      pulse_sof("s2", 1'b0);
      check_eq("s2_active", active_bank_o, 1);
      check_eq("s2_no_done", n_done, 0);

      // Long table: 20 beats, the last four drained.
      clear_log();
      start_load();
      check_eq("s3_err_cleared", err_o, 0);
      for (int i = 0; i < 20; i++) begin
         drive_beat(PxW'(3 - i), i == 19, 1'b0);
         if (i == 15) check_eq("s3_err_before_b15", err_o, 0);
         if (i == 16) check_eq("s3_err_after_b15", err_o, 1);
      end
      idle_cycle(1'b0);
      check_eq("s3_accepted", n_acc, 20);
      check_writes("s3", 16, 1'b0, 4'd3);
      check_eq("s3_idle", busy_o, 0);
      check_eq("s3_err", err_o, 1);

      // sof coincident with the final beat must not swap.
      clear_log();
      start_load();
      for (int i = 0; i < 16; i++) drive_beat(PxW'(9 - i), i == 15, i == 15);
      idle_cycle(1'b0);
      idle_cycle(1'b0);
      check_eq("s4_no_swap", active_bank_o, 1);
      check_eq("s4_still_waiting", busy_o, 1);
      check_writes("s4", 16, 1'b0, 4'd9);
      pulse_sof("s4", 1'b1);
      check_eq("s4_swapped", active_bank_o, 0);

      // Gapped valid with a stray load_start mid-load.
      clear_log();
      start_load();
      for (int i = 0; i < 16; i++) begin
         drive_beat(PxW'(12 - i), i == 15, 1'b0);
         idle_cycle(i == 5);
      end
      check_writes("s5", 16, 1'b1, 4'd12);
      pulse_sof("s5", 1'b1);
      check_eq("s5_active", active_bank_o, 1);

      // Reset asserted after beat 7, then a clean reload.
      clear_log();
      start_load();
      for (int i = 0; i < 8; i++) drive_beat(PxW'(5 + i), 1'b0, 1'b0);
      idle_cycle(1'b0);
      @(negedge clk_i);
      rst_n_i = 1'b0;
      #1;
      check_eq("s6_rst_outputs",
               {coef_tready_o, lut_wr_en_o, lut_wr_bank_o, lut_wr_addr_o, lut_wr_data_o,
                active_bank_o, busy_o, done_o, err_o}, 0);
      idle_cycle(1'b0);
      rst_n_i = 1'b1;
      idle_cycle(1'b0);
      clear_log();
      start_load();
      for (int i = 0; i < 16; i++) drive_beat(PxW'(15 - i), i == 15, 1'b0);
      idle_cycle(1'b0);
      pulse_sof("s6", 1'b1);
      check_writes("s6", 16, 1'b1, 4'd15);
      check_eq("s6_active", active_bank_o, 1);
      check_eq("s6_err", err_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/img_lut_bank_ctrl.md
IMG_LUT_BANK_CTRL -- requirements
Module: img_lut_bank_ctrl

Interface
REQ-001 The block SHALL have parameter PX_WIDTH, default 10, giving the pixel width, LUT address width and LUT data width.
REQ-002 The block SHALL define LUT_DEPTH = 2**PX_WIDTH as the number of entries per bank; it is not a parameter.
REQ-003 The block SHALL have these ports:
- clk_i  input  1  single clock.
- rst_n_i  input  1  asynchronous active-low reset.
- load_start_i  input  1  one-cycle request to load the shadow bank.
- coef_tdata_i  input  PX_WIDTH  coefficient stream data.
- coef_tvalid_i  input  1  coefficient beat valid.
- coef_tlast_i  input  1  last coefficient of the table.
- coef_tready_o  output  1  coefficient beat accepted.
- sof_i  input  1  start-of-frame handshake pulse from the datapath input (tvalid & tready & tuser).
- lut_wr_en_o  output  1  LUT RAM write strobe.
- lut_wr_bank_o  output  1  bank written.
- lut_wr_addr_o  output  PX_WIDTH  entry written.
- lut_wr_data_o  output  PX_WIDTH  value written.
- active_bank_o  output  1  bank read by the img_lut datapath.
- busy_o  output  1  state is not IDLE.
- done_o  output  1  one-cycle pulse on bank swap.
- err_o  output  1  sticky table-length error.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, DRAIN, WAIT_SOF.
REQ-005 IDLE: on load_start_i=1 the FSM SHALL clear the address counter and err_o, then go to LOAD.
REQ-006 In LOAD and DRAIN, coef_tready_o SHALL be 1; in all other states it SHALL be 0. coef_tready_o is decoded combinationally from the state register only.
REQ-007 A beat SHALL be accepted when coef_tvalid_i and coef_tready_o are both 1.
REQ-008 On each accepted beat in LOAD, the block SHALL register the write on the next edge:
- lut_wr_en_o = 1.
- lut_wr_bank_o = ~active_bank_o.
- lut_wr_addr_o = counter.
- lut_wr_data_o = coef_tdata_i.
Then the counter SHALL increment. Write latency is 1 cycle.
REQ-009 LOAD, accepted beat with tlast=1 and counter = LUT_DEPTH-1: write the beat, go to WAIT_SOF.
REQ-010 LOAD, accepted beat with tlast=1 and counter < LUT_DEPTH-1: write the beat, set err_o, go to IDLE. There SHALL be no swap.
REQ-011 LOAD, accepted beat with tlast=0 and counter = LUT_DEPTH-1: write the beat, set err_o, go to DRAIN.
REQ-012 The counter SHALL NOT wrap past LUT_DEPTH-1 in LOAD.
REQ-013 DRAIN SHALL accept and discard beats (lut_wr_en_o=0) until a beat with tlast=1 is accepted, then go to IDLE.
REQ-014 WAIT_SOF: on sof_i=1 the block SHALL toggle active_bank_o on the next edge, pulse done_o for exactly 1 cycle on that same edge, and go to IDLE.
REQ-015 sof_i SHALL be ignored outside WAIT_SOF, including sof_i on the same cycle as the final LOAD beat. The swap then waits for the following frame start.
REQ-016 load_start_i SHALL be ignored in every state except IDLE.
REQ-017 lut_wr_en_o SHALL be 1 for exactly 1 cycle per written entry; otherwise it SHALL be 0.
REQ-018 active_bank_o SHALL change only per REQ-014, so the active bank is never written.
REQ-019 err_o SHALL be cleared only by reset or by a load_start_i accepted in IDLE.

Reset
REQ-020 While rst_n_i=0, the block SHALL asynchronously force:
- state = IDLE, counter = 0.
- coef_tready_o = 0, lut_wr_en_o = 0, lut_wr_bank_o = 0, lut_wr_addr_o = 0, lut_wr_data_o = 0.
- active_bank_o = 0, busy_o = 0, done_o = 0, err_o = 0.
REQ-021 Reset asserted mid-LOAD SHALL abandon the load with no swap; the shadow bank contents are undefined.
REQ-022 Reset deassertion SHALL be used synchronised to clk_i by the integrator; the block needs no internal synchroniser.

Structure
REQ-023 The state enum typedef SHALL live in shared package img_lut_pkg.
REQ-024 The block SHALL be a single module (FSM plus counter) with no sub-module.

Verification
REQ-025 The bench SHALL use PX_WIDTH=4 (LUT_DEPTH=16) and cover these scenarios:
- Load of 16 beats, data=15-i, tlast on beat 15; sof_i 5 cycles later -> 16 writes to bank 1, addr 0..15, data 15..0; active_bank_o 0->1; one done_o pulse; err_o=0.
- tlast on beat 9 -> 10 writes; err_o=1; IDLE; active_bank_o unchanged; no done_o.
- 20 beats, tlast on beat 19 -> 16 writes; err_o=1 after beat 15; beats 16..19 accepted without writes; IDLE.
- sof_i on the same cycle as beat 15 -> no swap; next sof_i swaps.
- load_start_i in LOAD/WAIT_SOF -> ignored.
- coef_tvalid_i toggled every other cycle -> addresses stay contiguous.
- rst_n_i pulled low after beat 7 -> all outputs at reset values immediately; a new load afterwards completes normally into bank 1.
